spi_apb_arbiter: RTL and testbench

SPI_APB_ARBITER -- requirements
Module: spi_apb_arbiter

---
 rtl/spi_arb_pkg.sv | 18 +
 rtl/spi_arb_rr.sv | 26 ++
 rtl/spi_apb_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_spi_apb_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared definitions for the two-requester APB arbiter in front of
// the SPI flash/CSR bridge: FSM state encoding, requester count and default
// parameter values.
package spi_arb_pkg;

    localparam int unsigned NUM_REQ     = 2;
    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DRAIN  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/spi_arb_rr.sv
// spi_arb_rr: 2-way round-robin pick.
//   req[1:0]   : request vector (bit N = requester N)
//   last_grant : requester served most recently
//   grant      : requester to serve (meaningful when valid=1)
//   valid      : at least one request present
module spi_arb_rr
    import spi_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_grant,
    output logic               grant,
    output logic               valid
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (&req) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/spi_apb_arbiter.sv
// spi_apb_arbiter: arbitrates two APB requesters onto one APB completer port
// (the shared SPI flash/CSR bridge). Round-robin on ties, payload forwarded
// live from the granted requester, response returned combinationally in the
// completing ACCESS cycle.
//
// Ports
//   clk, resetn                 : clock, asynchronous active-low reset
//   mN_psel/penable/pwrite/...  : requester N APB request (N = 0,1)
//   mN_pready/prdata/pslverr    : requester N response (0 when not granted)
//   s_*                         : APB toward the bridge
//   grant_id                    : currently or last granted requester
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT cycles with an error to the requester; the bridge transfer is then
// drained in the DRAIN state before any new grant.
module spi_apb_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  m0_psel,
    input  logic                  m0_penable,
    input  logic                  m0_pwrite,
    input  logic [ADDR_W-1:0]     m0_paddr,
    input  logic [DATA_W-1:0]     m0_pwdata,
    input  logic [DATA_W/8-1:0]   m0_pstrb,
    input  logic [2:0]            m0_pprot,
    output logic                  m0_pready,
    output logic [DATA_W-1:0]     m0_prdata,
    output logic                  m0_pslverr,

    input  logic                  m1_psel,
    input  logic                  m1_penable,
    input  logic                  m1_pwrite,
    input  logic [ADDR_W-1:0]     m1_paddr,
    input  logic [DATA_W-1:0]     m1_pwdata,
    input  logic [DATA_W/8-1:0]   m1_pstrb,
    input  logic [2:0]            m1_pprot,
    output logic                  m1_pready,
    output logic [DATA_W-1:0]     m1_prdata,
    output logic                  m1_pslverr,

    output logic                  s_psel,
    output logic                  s_penable,
    output logic                  s_pwrite,
    output logic [ADDR_W-1:0]     s_paddr,
    output logic [DATA_W-1:0]     s_pwdata,
    output logic [DATA_W/8-1:0]   s_pstrb,
    output logic [2:0]            s_pprot,
    input  logic                  s_pready,
    input  logic [DATA_W-1:0]     s_prdata,
    input  logic                  s_pslverr,

    output logic                  grant_id
);

    localparam int unsigned STRB_W = DATA_W / 8;

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic       s_psel_q, s_psel_d;
    logic       s_penable_q, s_penable_d;

    logic       rr_grant;
    logic       rr_valid;
    logic       done_c;
    logic       timeout_c;
    logic       resp_valid_c;

    // Requester penable is implied by the arbiter's own phase tracking.
    logic       unused_c;
    assign unused_c = ^{m0_penable, m1_penable, 32'(TIMEOUT)};

    spi_arb_rr u_rr (
        .req        ({m1_psel, m0_psel}),
        .last_grant (last_q),
        .grant      (rr_grant),
        .valid      (rr_valid)
    );

    // Live payload of the granted requester.
    logic              live_write;
    logic [ADDR_W-1:0] live_addr;
    logic [DATA_W-1:0] live_wdata;
    logic [STRB_W-1:0] live_strb;
    logic [2:0]        live_prot;

    always_comb begin
        live_write = grant_q ? m1_pwrite : m0_pwrite;
        live_addr  = grant_q ? m1_paddr  : m0_paddr;
        live_wdata = grant_q ? m1_pwdata : m0_pwdata;
        live_strb  = grant_q ? m1_pstrb  : m0_pstrb;
        live_prot  = grant_q ? m1_pprot  : m0_pprot;
    end

    assign done_c = (state_q == ACCESS) && s_pready;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drain_write_q;
    logic [ADDR_W-1:0] drain_addr_q;
    logic [DATA_W-1:0] drain_wdata_q;
    logic [STRB_W-1:0] drain_strb_q;
    logic [2:0]        drain_prot_q;

    // cnt_q holds the number of ACCESS cycles already elapsed.
    assign timeout_c = (state_q == ACCESS) && !s_pready
                       && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign cnt_d     = (state_q == ACCESS) ? cnt_q + CNT_W'(1) : '0;

    // Payload frozen at timeout; the requester is released and may move on.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q         <= '0;
            drain_write_q <= 1'b0;
            drain_addr_q  <= '0;
            drain_wdata_q <= '0;
            drain_strb_q  <= '0;
            drain_prot_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (timeout_c) begin
                drain_write_q <= live_write;
                drain_addr_q  <= live_addr;
                drain_wdata_q <= live_wdata;
                drain_strb_q  <= live_strb;
                drain_prot_q  <= live_prot;
            end
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    assign resp_valid_c = done_c || timeout_c;

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        s_psel_d    = 1'b0;
        s_penable_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rr_valid) begin
                    state_d = SETUP;
                    grant_d = rr_grant;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (done_c) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else if (timeout_c) begin
                    state_d = DRAIN;
                    last_d  = grant_q;
                end
            end
            DRAIN: begin
                if (s_pready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        s_psel_d    = (state_d != IDLE);
        s_penable_d = (state_d == ACCESS) || (state_d == DRAIN);
    end

    // State and registered bus control.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            s_psel_q    <= 1'b0;
            s_penable_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            s_psel_q    <= s_psel_d;
            s_penable_q <= s_penable_d;
        end
    end

    assign s_psel    = s_psel_q;
    assign s_penable = s_penable_q;
    assign grant_id  = grant_q;

    // Bridge payload: zero in IDLE, frozen copy in DRAIN, live otherwise.
    always_comb begin
        s_pwrite = 1'b0;
        s_paddr  = '0;
        s_pwdata = '0;
        s_pstrb  = '0;
        s_pprot  = '0;
        if (state_q != IDLE) begin
            s_pwrite = live_write;
            s_paddr  = live_addr;
            s_pwdata = live_wdata;
            s_pstrb  = live_strb;
            s_pprot  = live_prot;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        if (state_q == DRAIN) begin
            s_pwrite = drain_write_q;
            s_paddr  = drain_addr_q;
            s_pwdata = drain_wdata_q;
            s_pstrb  = drain_strb_q;
            s_pprot  = drain_prot_q;
        end
`endif
    end

    // Responses go only to the granted requester, and only while it still
    // selects; a completion for a requester that let go is dropped.
    always_comb begin
        m0_pready  = 1'b0;
        m0_prdata  = '0;
        m0_pslverr = 1'b0;
        m1_pready  = 1'b0;
        m1_prdata  = '0;
        m1_pslverr = 1'b0;
        if (resp_valid_c && !grant_q && m0_psel) begin
            m0_pready  = 1'b1;
            m0_prdata  = timeout_c ? '0 : s_prdata;
            m0_pslverr = timeout_c ? 1'b1 : s_pslverr;
        end
        if (resp_valid_c && grant_q && m1_psel) begin
            m1_pready  = 1'b1;
            m1_prdata  = timeout_c ? '0 : s_prdata;
            m1_pslverr = timeout_c ? 1'b1 : s_pslverr;
        end
    end

endmodule

// File: tb/tb_spi_apb_arbiter.sv
module tb_spi_apb_arbiter;

    logic        clk = 1'b0;
    logic        resetn;

    logic        m0_psel, m0_penable, m0_pwrite;
    logic [31:0] m0_paddr, m0_pwdata;
    logic [3:0]  m0_pstrb;
    logic [2:0]  m0_pprot;
    logic        m0_pready, m0_pslverr;
    logic [31:0] m0_prdata;

    logic        m1_psel, m1_penable, m1_pwrite;
    logic [31:0] m1_paddr, m1_pwdata;
    logic [3:0]  m1_pstrb;
    logic [2:0]  m1_pprot;
    logic        m1_pready, m1_pslverr;
    logic [31:0] m1_prdata;

    logic        s_psel, s_penable, s_pwrite;
    logic [31:0] s_paddr, s_pwdata;
    logic [3:0]  s_pstrb;
    logic [2:0]  s_pprot;
    logic        s_pready, s_pslverr;
    logic [31:0] s_prdata;
    logic        grant_id;

    int total = 0;
    int bad   = 0;

    spi_apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .m0_psel    (m0_psel),
        .m0_penable (m0_penable),
        .m0_pwrite  (m0_pwrite),
        .m0_paddr   (m0_paddr),
        .m0_pwdata  (m0_pwdata),
        .m0_pstrb   (m0_pstrb),
        .m0_pprot   (m0_pprot),
        .m0_pready  (m0_pready),
        .m0_prdata  (m0_prdata),
        .m0_pslverr (m0_pslverr),
        .m1_psel    (m1_psel),
        .m1_penable (m1_penable),
        .m1_pwrite  (m1_pwrite),
        .m1_paddr   (m1_paddr),
        .m1_pwdata  (m1_pwdata),
        .m1_pstrb   (m1_pstrb),
        .m1_pprot   (m1_pprot),
        .m1_pready  (m1_pready),
        .m1_prdata  (m1_prdata),
        .m1_pslverr (m1_pslverr),
        .s_psel     (s_psel),
        .s_penable  (s_penable),
        .s_pwrite   (s_pwrite),
        .s_paddr    (s_paddr),
        .s_pwdata   (s_pwdata),
        .s_pstrb    (s_pstrb),
        .s_pprot    (s_pprot),
        .s_pready   (s_pready),
        .s_prdata   (s_prdata),
        .s_pslverr  (s_pslverr),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_paddr = '0; m0_pwdata = '0;
        m0_pstrb = '0; m0_pprot = '0;
        m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_paddr = '0; m1_pwdata = '0;
        m1_pstrb = '0; m1_pprot = '0;
        s_pready = 0; s_prdata = '0; s_pslverr = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
    endtask

    // Called in an IDLE cycle with the requester(s) already selecting.
    // Returns in the IDLE cycle after completion.
    task automatic run_xfer(input logic gid, input logic [31:0] addr, input int acc_cycles,
                            input logic [31:0] rdata, input logic err);
        tick();
        check("setup_psel", s_psel, 1);
        check("setup_penable", s_penable, 0);
        check("setup_gid", grant_id, gid);
        check("setup_paddr", s_paddr, addr);
        check("setup_pwrite", s_pwrite, gid ? m1_pwrite : m0_pwrite);
        check("setup_pwdata", s_pwdata, gid ? m1_pwdata : m0_pwdata);
        if (gid) m1_penable = 1; else m0_penable = 1;
        tick();
        for (int i = 1; i < acc_cycles; i++) begin
            check("acc_penable", s_penable, 1);
            check("acc_no_ready", {m0_pready, m1_pready}, 2'b00);
            tick();
        end
        s_pready = 1; s_prdata = rdata; s_pslverr = err;
        #1;
        check("rsp_m0_pready", m0_pready, !gid);
        check("rsp_m1_pready", m1_pready, gid);
        check("rsp_m0_prdata", m0_prdata, gid ? 32'h0 : rdata);
        check("rsp_m1_prdata", m1_prdata, gid ? rdata : 32'h0);
        check("rsp_m0_pslverr", m0_pslverr, gid ? 1'b0 : err);
        check("rsp_m1_pslverr", m1_pslverr, gid ? err : 1'b0);
        tick();
        s_pready = 0; s_prdata = '0; s_pslverr = 0;
        m0_penable = 0; m1_penable = 0;
        #1;
        check("idle_psel", s_psel, 0);
        check("idle_paddr", s_paddr, 0);
        check("idle_m_pready", {m0_pready, m1_pready}, 2'b00);
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        do_reset();

        // Reset state
        check("rst_psel", s_psel, 0);
        check("rst_penable", s_penable, 0);
        check("rst_gid", grant_id, 0);
        check("rst_paddr", s_paddr, 0);

        // m0 read alone, 3 ACCESS cycles
        m0_psel = 1; m0_paddr = 32'h3000_0010; m0_pwrite = 0;
        #1;
        check("idle_before_psel", s_psel, 0);
        run_xfer(1'b0, 32'h3000_0010, 3, 32'hDEAD_BEEF, 1'b0);
        m0_psel = 0;

        // Simultaneous requests after reset: m0 then m1
        do_reset();
        m0_psel = 1; m0_paddr = 32'h0000_0100;
        m1_psel = 1; m1_paddr = 32'h0000_0200;
        run_xfer(1'b0, 32'h0000_0100, 1, 32'h1111_0000, 1'b0);
        m0_psel = 0;
        run_xfer(1'b1, 32'h0000_0200, 2, 32'h2222_0000, 1'b0);
        m1_psel = 0;

        // Continuous requesters alternate strictly
        do_reset();
        m0_psel = 1; m0_paddr = 32'h0000_0A00;
        m1_psel = 1; m1_paddr = 32'h0000_0B00;
        for (int i = 0; i < 6; i++) begin
            run_xfer(1'(i % 2), (i % 2) ? 32'h0000_0B00 : 32'h0000_0A00, 1 + (i % 3),
                     32'h5000_0000 + 32'(i), 1'b0);
        end
        m0_psel = 0; m1_psel = 0;

        // Reset in the middle of m1's ACCESS
        do_reset();
        m0_psel = 1; m0_paddr = 32'h0000_0C00;
        run_xfer(1'b0, 32'h0000_0C00, 1, 32'h0, 1'b0);
        m0_psel = 0;
        m1_psel = 1; m1_paddr = 32'h0000_0D00;
        tick();
        tick();
        check("mid_acc_penable", s_penable, 1);
        check("mid_acc_gid", grant_id, 1);
        resetn = 0;
        #1;
        check("async_rst_psel", s_psel, 0);
        check("async_rst_penable", s_penable, 0);
        check("async_rst_gid", grant_id, 0);
        s_pready = 1;
        #1;
        check("async_rst_m1_pready", m1_pready, 0);
        s_pready = 0;
        tick();
        tick();
        resetn = 1;
        m0_psel = 1;
        #1;
        check("post_rst_idle", s_psel, 0);
        run_xfer(1'b0, 32'h0000_0C00, 1, 32'h0, 1'b0);
        m0_psel = 0;
        run_xfer(1'b1, 32'h0000_0D00, 1, 32'h0, 1'b0);
        m1_psel = 0;

        // m1 write with slave error
        m1_psel = 1; m1_pwrite = 1; m1_paddr = 32'h1000_0018;
        m1_pwdata = 32'hA5A5_1234; m1_pstrb = 4'hF;
        run_xfer(1'b1, 32'h1000_0018, 2, 32'h0, 1'b1);
        m1_psel = 0; m1_pwrite = 0;

`ifdef SPI_ARB_TIMEOUT_EN
        // Withheld pready: error at ACCESS cycle 8, drain, then m1
        do_reset();
        m0_psel = 1; m0_paddr = 32'h0000_0E00;
        m1_psel = 1; m1_paddr = 32'h0000_0F00;
        tick();
        check("to_setup_gid", grant_id, 0);
        tick();
        for (int i = 1; i < 8; i++) begin
            check("to_wait_ready", m0_pready, 0);
            tick();
        end
        check("to_m0_pready", m0_pready, 1);
        check("to_m0_pslverr", m0_pslverr, 1);
        check("to_m0_prdata", m0_prdata, 0);
        check("to_m1_pready", m1_pready, 0);
        m0_psel = 0; m0_paddr = 32'h0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("drain_psel", s_psel, 1);
            check("drain_penable", s_penable, 1);
            check("drain_paddr", s_paddr, 32'h0000_0E00);
            check("drain_gid", grant_id, 0);
        end
        s_pready = 1; s_prdata = 32'h7777_7777;
        #1;
        check("drain_no_resp", {m0_pready, m1_pready}, 2'b00);
        tick();
        s_pready = 0; s_prdata = '0;
        #1;
        check("drain_to_idle", s_psel, 0);
        run_xfer(1'b1, 32'h0000_0F00, 1, 32'h0, 1'b0);
        m1_psel = 0;
`else
        // Without the timeout feature ACCESS waits as long as needed
        do_reset();
        m0_psel = 1; m0_paddr = 32'h0000_0E00;
        run_xfer(1'b0, 32'h0000_0E00, 21, 32'h1234_5678, 1'b0);
        m0_psel = 0;
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
